// File: rtl/isa_pkg.sv
// isa_pkg: opcode/funct constants, mnemonic codes and field widths shared with the control decoder
package isa_pkg;
  localparam int OP_W = 6;
  localparam int REG_W = 5;
  localparam int MNEM_W = 5;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SGT   = 6'h2c;
  typedef enum logic [MNEM_W-1:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_NOR, M_XOR, M_SLT, M_SGT, M_SLL, M_SRL, M_JR,
    M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL
  } mnem_e;
  typedef enum logic [2:0] {FMT_R, FMT_SH, FMT_JR, FMT_I, FMT_J} fmt_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/instr_encode_loader_if.sv
// instr_encode_loader_if: valid/ready stream carrying symbolic instruction fields
interface instr_encode_loader_if;
  import isa_pkg::*;
  logic in_valid, in_ready, in_last;
  logic [MNEM_W-1:0] in_mnem;
  logic [REG_W-1:0] in_rd, in_rs, in_rt;
  logic [TGT_W-1:0] in_imm;
  modport master(output in_valid, in_last, in_mnem, in_rd, in_rs, in_rt, in_imm, input in_ready);
  modport slave(input in_valid, in_last, in_mnem, in_rd, in_rs, in_rt, in_imm, output in_ready);
endinterface

// File: rtl/instr_field_encoder.sv
// instr_field_encoder: maps a mnemonic and its fields to a 32-bit MIPS word plus a legality flag
module instr_field_encoder
  import isa_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [TGT_W-1:0]  imm,
  output logic [31:0]       word,
  output logic              legal
);
  fmt_e fmt;
  logic [5:0] code;
  // pick the instruction format and its opcode or funct; unknown codes are illegal
  always_comb begin
    fmt = FMT_R;
    code = '0;
    legal = 1'b1;
    case (mnem)
      M_ADD:  code = FN_ADD;
      M_SUB:  code = FN_SUB;
      M_AND:  code = FN_AND;
      M_OR:   code = FN_OR;
      M_NOR:  code = FN_NOR;
      M_XOR:  code = FN_XOR;
      M_SLT:  code = FN_SLT;
      M_SGT:  code = FN_SGT;
      M_SLL:  begin fmt = FMT_SH; code = FN_SLL; end
      M_SRL:  begin fmt = FMT_SH; code = FN_SRL; end
      M_JR:   begin fmt = FMT_JR; code = FN_JR; end
      M_ADDI: begin fmt = FMT_I; code = OP_ADDI; end
      M_ANDI: begin fmt = FMT_I; code = OP_ANDI; end
      M_ORI:  begin fmt = FMT_I; code = OP_ORI; end
      M_XORI: begin fmt = FMT_I; code = OP_XORI; end
      M_SLTI: begin fmt = FMT_I; code = OP_SLTI; end
      M_LW:   begin fmt = FMT_I; code = OP_LW; end
      M_SW:   begin fmt = FMT_I; code = OP_SW; end
      M_BEQ:  begin fmt = FMT_I; code = OP_BEQ; end
      M_BNE:  begin fmt = FMT_I; code = OP_BNE; end
      M_J:    begin fmt = FMT_J; code = OP_J; end
      M_JAL:  begin fmt = FMT_J; code = OP_JAL; end
      default: legal = 1'b0;
    endcase
  end
  // assemble the word for the selected format
  always_comb begin
    word = !legal         ? '0 :
           fmt == FMT_R   ? {OP_RTYPE, rs, rt, rd, 5'd0, code} :
           fmt == FMT_SH  ? {OP_RTYPE, 5'd0, rt, rd, imm[4:0], code} :
           fmt == FMT_JR  ? {OP_RTYPE, rs, 15'd0, code} :
           fmt == FMT_I   ? {code, rs, rt, imm[IMM_W-1:0]} :
                            {code, imm};
  end
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes a stream of symbolic instructions and writes them sequentially into instruction memory
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encode_loader_if.slave  bus,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [CW-1:0]         count,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err
);
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, acc_q, acc_d;
  logic we_q, we_d, err_q, err_d, full_q, full_d;
  logic [31:0] word_q, word_d, enc_word;
  logic enc_legal, xfer, discard;

  instr_field_encoder u_enc (
    .mnem(bus.in_mnem), .rd(bus.in_rd), .rs(bus.in_rs), .rt(bus.in_rt), .imm(bus.in_imm),
    .word(enc_word), .legal(enc_legal)
  );

  assign bus.in_ready = state_q == S_LOAD && acc_q < CW'(DEPTH);
  assign xfer = bus.in_valid && bus.in_ready;
  // once DEPTH legal words are in, only a last-marked beat is consumed, and it is dropped
  assign discard = state_q == S_LOAD && bus.in_valid && bus.in_last && acc_q == CW'(DEPTH);

  // session sequencing, accept bookkeeping and the one-deep write pipeline
  always_comb begin
    state_d = state_q;
    count_d = count_q + CW'(we_q);
    acc_d = acc_q;
    err_d = err_q;
    full_d = full_q || (we_q && state_q == S_LOAD && count_q + CW'(1) == CW'(DEPTH));
    we_d = 1'b0;
    word_d = word_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        count_d = '0;
        acc_d = '0;
        err_d = 1'b0;
        full_d = 1'b0;
      end
      S_LOAD: if (xfer) begin
        we_d = enc_legal;
        word_d = enc_word;
        acc_d = acc_q + CW'(enc_legal);
        err_d = err_q || !enc_legal;
        state_d = bus.in_last ? S_DRAIN : S_LOAD;
      end else if (discard) state_d = S_DONE;
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and pipeline registers; reset drops any pending write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q <= '0;
      we_q <= 1'b0;
      word_q <= '0;
      err_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q <= acc_d;
      we_q <= we_d;
      word_q <= word_d;
      err_q <= err_d;
      full_q <= full_d;
    end
  end

  assign imem_we = we_q;
  assign imem_addr = we_q ? ADDR_W'(BASE_ADDR + (32'(count_q) << 2)) : '0;
  assign imem_wdata = we_q ? word_q : '0;
  assign count = count_q;
  assign busy = state_q == S_LOAD || state_q == S_DRAIN;
  assign done = state_q == S_DONE;
  assign full = full_q;
  assign err = err_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: randomized and directed load sessions scored against a table-driven encoder model
module tb_instr_encode_loader;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  instr_encode_loader_if bus();
  logic imem_we, busy, done, full, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0] count;

  instr_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .full(full), .err(err)
  );

  typedef struct {int m; logic [4:0] rd, rs, rt; logic [25:0] imm; bit last; int gap; bit st;} ins_t;
  typedef struct {logic [31:0] addr, data; int cyc;} wr_t;
  ins_t prog[$];
  wr_t got[$], exp_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, legal_n, err_e;

  // opcode for I/J formats, funct for R formats, indexed by mnemonic code
  int code_t[22] = '{'h20, 'h22, 'h24, 'h25, 'h27, 'h26, 'h2a, 'h2c, 'h00, 'h02, 'h08,
                     'h08, 'h0c, 'h0d, 'h0e, 'h0a, 'h23, 'h2b, 'h04, 'h05, 'h02, 'h03};

  always @(posedge clk) cyc++;
  always @(negedge clk) if (imem_we) got.push_back('{imem_addr, imem_wdata, cyc});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_enc(int m, logic [4:0] rd, rs, rt, logic [25:0] imm);
    logic [5:0] c;
    c = 6'(code_t[m]);
    if (m <= 7) return {6'd0, rs, rt, rd, 5'd0, c};
    if (m <= 9) return {6'd0, 5'd0, rt, rd, imm[4:0], c};
    if (m == 10) return {6'd0, rs, 15'd0, c};
    if (m <= 19) return {c, rs, rt, imm[15:0]};
    return {c, imm};
  endfunction

  function automatic ins_t mk(int m, int rd, int rs, int rt, int imm, bit last, int gap = 0, bit st = 0);
    ins_t p;
    p.m = m; p.rd = 5'(rd); p.rs = 5'(rs); p.rt = 5'(rt); p.imm = 26'(imm);
    p.last = last; p.gap = gap; p.st = st;
    return p;
  endfunction

  function automatic logic [31:0] wd(int i);
    return got.size() > i ? got[i].data : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wa(int i);
    return got.size() > i ? got[i].addr : 32'hxxxx_xxxx;
  endfunction

  function automatic int wc(int i);
    return got.size() > i ? got[i].cyc : -100;
  endfunction

  task automatic check(string tag, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, req);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    check("count_cleared", count, 0);
    check("err_cleared", err, 0);
  endtask

  task automatic drive(ins_t p);
    bus.in_mnem = 5'(p.m); bus.in_rd = p.rd; bus.in_rs = p.rs; bus.in_rt = p.rt;
    bus.in_imm = p.imm; bus.in_last = p.last; bus.in_valid = 1'b1;
  endtask

  task automatic send(ins_t p);
    drive(p);
    start = p.st;
    for (int n = 0; n < 20 && !bus.in_ready; n++) begin @(posedge clk); #1; end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    for (int n = 0; n < 30 && !done; n++) @(negedge clk);
    check("done_seen", done, 1);
  endtask

  task automatic compare_writes();
    check("n_writes", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check("wr_addr", got[i].addr, exp_q[i].addr);
      check("wr_data", got[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_session();
    legal_n = 0;
    err_e = 0;
    exp_q.delete();
    got.delete();
    pulse_start();
    foreach (prog[i]) begin
      bus.in_valid = 1'b0;
      repeat (prog[i].gap) begin @(posedge clk); #1; end
      send(prog[i]);
      if (prog[i].m < 22) begin
        exp_q.push_back('{BASE + 32'(4 * legal_n),
                         ref_enc(prog[i].m, prog[i].rd, prog[i].rs, prog[i].rt, prog[i].imm), 0});
        legal_n++;
      end else err_e = 1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    wait_done();
    check("count_final", count, legal_n);
    check("err_final", err, err_e);
    check("full_final", full, 0);
    check("busy_in_done", busy, 0);
    compare_writes();
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mnem = '0;
    bus.in_rd = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_imm = '0;
    @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bus.in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;

    prog = '{mk(0, 3, 1, 2, 0, 1)};
    run_session();
    check("t1_word", wd(0), 32'h0022_1820);
    check("t1_addr", wa(0), 32'h0);

    prog = '{mk(11, 0, 0, 5, 7, 0), mk(8, 4, 0, 2, 3, 0), mk(16, 0, 29, 8, 4, 1)};
    run_session();
    check("t2_w0", wd(0), 32'h2005_0007);
    check("t2_w1", wd(1), 32'h0002_20C0);
    check("t2_w2", wd(2), 32'h8FA8_0004);
    check("t2_a2", wa(2), 32'h8);
    check("t2_b2b_1", wc(1) - wc(0), 1);
    check("t2_b2b_2", wc(2) - wc(1), 1);

    prog = '{mk(18, 0, 1, 2, 'hFFFF, 0), mk(21, 0, 0, 0, 'h10, 1)};
    run_session();
    check("t3_w0", wd(0), 32'h1022_FFFF);
    check("t3_w1", wd(1), 32'h0C00_0010);

    prog = '{mk(0, 3, 1, 2, 0, 0), mk(25, 1, 1, 1, 0, 0, 0, 1), mk(0, 6, 4, 5, 0, 1)};
    run_session();
    check("t4_err", err, 1);
    check("t4_a1", wa(1), 32'h4);

    prog = '{mk(12, 0, 1, 2, 9, 0), mk(13, 0, 3, 4, 8, 0), mk(10, 0, 31, 0, 0, 0), mk(20, 0, 0, 0, 'h3FFFFFF, 1)};
    run_session();

    prog = '{mk(27, 0, 0, 0, 0, 1)};
    run_session();

    got.delete();
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(mk(11, 0, i, i + 1, 3 * i, 0));
    drive(mk(0, 1, 2, 3, 0, 0));
    repeat (3) begin
      @(negedge clk);
      check("full_ready_low", bus.in_ready, 0);
    end
    check("full_flag", full, 1);
    check("full_count", count, DEPTH);
    check("full_nwr", got.size(), DEPTH);
    check("full_a3", wa(3), 32'hC);
    check("full_w3", wd(3), ref_enc(11, 0, 3, 4, 9));
    @(posedge clk); #1 bus.in_last = 1'b1;
    wait_done();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    check("discard_count", count, DEPTH);
    check("discard_nwr", got.size(), DEPTH);
    check("full_hold", full, 1);
    @(negedge clk);
    check("discard_done_once", done, 0);

    got.delete();
    pulse_start();
    send(mk(0, 1, 2, 3, 0, 0));
    send(mk(30, 0, 0, 0, 0, 0));
    drive(mk(1, 7, 8, 9, 0, 0));
    @(posedge clk); #1 rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_nwr", got.size(), 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", bus.in_ready, 0);
    check("post_rst_we", imem_we, 0);

    repeat (40) begin
      int n, m;
      prog.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        m = ($urandom_range(0, 5) == 0) ? $urandom_range(22, 31) : $urandom_range(0, 21);
        prog.push_back(mk(m, $urandom, $urandom, $urandom, $urandom, i == n - 1,
                          $urandom_range(0, 2), $urandom_range(0, 7) == 0));
      end
      run_session();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
